cdc_handshake_tx: RTL and testbench

Source-domain transmitter for a two-phase (toggle) req/ack clock-domain-crossing handshake. It accepts one N-bit word through a valid/ready port, holds it stable on `tx_data`, and toggles `tx_req` toward the destination domain. It then waits for the destination's acknowledge toggle, which it brings into `clk` through an internal multi-flop synchronizer, before accepting the next word. It is the sending end paired with the destination-side synchronizer that captures `tx_req`/`tx_data`.

---
 rtl/cdc_handshake_tx_if.sv | 29 ++
 rtl/cdc_handshake_tx.sv | 116 +++++++++++
 tb/tb_cdc_handshake_tx.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_handshake_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx_if
// Brief    : Upstream valid/ready port plus toggle req/ack crossing signals.
// Revision : 1.0
// ============================================================================
interface cdc_handshake_tx_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;
    logic [N-1:0] tx_data;
    logic         tx_req;
    logic         ack_async;

    // Environment side: produces words and the destination acknowledge.
    modport master (
        output in_valid, in_data, ack_async,
        input  in_ready, tx_data, tx_req
    );

    // Transmitter side.
    modport slave (
        input  in_valid, in_data, ack_async,
        output in_ready, tx_data, tx_req
    );
endinterface
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Brief    : Source end of a two-phase req/ack CDC handshake with ack timeout.
// Revision : 1.0
// ============================================================================
module cdc_handshake_tx #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int CW          = 8
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               ena,
    cdc_handshake_tx_if.slave bus,
    output logic              busy,
    output logic              err_timeout,
    input  wire               err_clr
);

    localparam logic [CW-1:0] c_timeout    = CW'(TIMEOUT);
    localparam logic [CW-1:0] c_timeout_m1 = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N-1:0]           r_tx_data;
    logic [N-1:0]           w_tx_data_nxt;
    logic                   r_tx_req;
    logic                   w_tx_req_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ack_sync;

    // Acknowledge synchronizer; frozen together with everything else by ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else if (ena) begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ack_async};
        end
    end

    assign w_ack_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx_data <= '0;
            r_tx_req  <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_req  <= w_tx_req_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_data_nxt = r_tx_data;
        w_tx_req_nxt  = r_tx_req;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;

        if (ena) begin
            // Clear first so a same-edge timeout set below takes priority.
            if (err_clr) begin
                w_err_nxt = 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        w_tx_data_nxt = bus.in_data;
                        w_tx_req_nxt  = ~r_tx_req;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_ack_sync == r_tx_req) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt != c_timeout) begin
                        w_cnt_nxt = r_cnt + CW'(1);
                        if (r_cnt == c_timeout_m1) begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = (r_state == S_IDLE);
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_req   = r_tx_req;
    assign busy         = (r_state == S_WAIT);
    assign err_timeout  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Brief    : Directed bench with a tx_req-toggle scoreboard for cdc_handshake_tx.
// Revision : 1.0
// ============================================================================
module tb_cdc_handshake_tx;

    localparam int N           = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 4;
    localparam int CW          = 8;
    // Echoed req is sampled one edge late, then SYNC_STAGES edges to IDLE,
    // then one IDLE cycle before the next acceptance edge.
    localparam int GAP         = SYNC_STAGES + 2;

    typedef struct {
        logic [N-1:0] data;
        logic         req;
        int           gap;
    } exp_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic ena     = 1'b1;
    logic err_clr = 1'b0;
    logic busy;
    logic err_timeout;
    logic loop_en = 1'b0;
    logic ack_drv = 1'b0;

    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    exp_t sb_q[$];

    cdc_handshake_tx_if #(.N(N)) bus ();

    assign bus.ack_async = loop_en ? bus.tx_req : ack_drv;

    cdc_handshake_tx #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT),
        .CW          (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] d, input logic r, input int g);
        exp_t e;
        e.data = d;
        e.req  = r;
        e.gap  = g;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s: in_ready stayed 0 for %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        loop_en      = 1'b0;
        ack_drv      = 1'b0;
        bus.in_valid = 1'b0;
        err_clr      = 1'b0;
        ena          = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: every tx_req toggle is one accepted word; compare with scoreboard.
    initial begin : monitor
        logic prev;
        int   last;
        exp_t e;
        prev = 1'b0;
        last = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev = 1'b0;
            end else if (bus.tx_req !== prev) begin
                prev = bus.tx_req;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: tx_req toggled to %0b with no word expected", bus.tx_req);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", 32'(bus.tx_data), 32'(e.data));
                    check("sb_req", 32'(bus.tx_req), 32'(e.req));
                    if (e.gap != 0) check("sb_gap", cyc - last, e.gap);
                end
                last = cyc;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [N-1:0] words [3];
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset values
        step();
        step();
        check("rst_busy_during", 32'(busy), 0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_tx_req", 32'(bus.tx_req), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err_timeout), 0);

        // Single transfer, acknowledge sampled at edge e -> IDLE at e+2
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        push(8'hA5, 1'b1, 0);
        step();
        bus.in_valid = 1'b0;
        check("single_in_ready_low", 32'(bus.in_ready), 0);
        check("single_busy", 32'(busy), 1);
        ack_drv = 1'b1;
        step();
        check("single_wait_e", 32'(bus.in_ready), 0);
        step();
        check("single_wait_e1", 32'(bus.in_ready), 0);
        step();
        check("single_ready_e2", 32'(bus.in_ready), 1);
        check("single_busy_e2", 32'(busy), 0);
        check("single_no_err", 32'(err_timeout), 0);

        // Back-to-back with loopback destination
        do_reset();
        loop_en      = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = words[i];
            push(words[i], (i % 2 == 0) ? 1'b1 : 1'b0, (i == 0) ? 0 : GAP);
            wait_ready("loop_wait");
            step();
        end
        bus.in_valid = 1'b0;
        wait_ready("loop_final");
        check("loop_tx_req_end", 32'(bus.tx_req), 1);
        ack_drv = 1'b1;
        loop_en = 1'b0;

        // Enable freeze while in WAIT
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        push(8'h3C, 1'b0, 0);
        step();
        bus.in_valid = 1'b0;
        ena          = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ack_drv = ~ack_drv;
            step();
        end
        ack_drv = 1'b0;
        step();
        check("freeze_busy", 32'(busy), 1);
        check("freeze_in_ready", 32'(bus.in_ready), 0);
        check("freeze_tx_data", 32'(bus.tx_data), 32'h3C);
        ena = 1'b1;
        step();
        check("freeze_e", 32'(busy), 1);
        step();
        check("freeze_e1", 32'(busy), 1);
        step();
        check("freeze_idle_e2", 32'(bus.in_ready), 1);

        // Timeout with TIMEOUT=4, set/clear collision, sticky flag, late ack
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        push(8'h5A, 1'b1, 0);
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("to_err_early", 32'(err_timeout), 0);
        end
        err_clr = 1'b1;
        step();
        check("to_err_set_wins", 32'(err_timeout), 1);
        err_clr = 1'b0;
        step();
        step();
        check("to_err_sticky", 32'(err_timeout), 1);
        check("to_still_busy", 32'(busy), 1);
        err_clr = 1'b1;
        step();
        check("to_err_cleared", 32'(err_timeout), 0);
        err_clr = 1'b0;
        step();
        check("to_err_stays_clear", 32'(err_timeout), 0);
        ack_drv = 1'b1;
        step();
        step();
        check("to_late_ack_wait", 32'(busy), 1);
        step();
        check("to_late_ack_idle", 32'(bus.in_ready), 1);

        // Asynchronous reset mid-transfer
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        push(8'hC3, 1'b1, 0);
        step();
        bus.in_valid = 1'b0;
        check("mid_busy", 32'(busy), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_req", 32'(bus.tx_req), 0);
        check("mid_rst_tx_data", 32'(bus.tx_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("mid_rel_in_ready", 32'(bus.in_ready), 1);
        check("mid_rel_tx_req", 32'(bus.tx_req), 0);

        step();
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
